// File: rtl/bank_sram_ctrl.sv
// Bank SRAM controller: accepts one issued op at a time from the bank issue
// queue and sequences data-SRAM, write-buffer and linefill-buffer accesses,
// returning read data / write acks and streaming dirty evictions to the BIU.
module bank_sram_ctrl #(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // issue queue handshake
  input  logic                  iq_sc_valid_i,
  output logic                  iq_sc_ready_o,
  input  logic [1:0]            iq_sc_channel_id_i,
  input  logic [2:0]            iq_sc_opcode_i,
  input  logic [6:0]            iq_sc_set_way_offset_i,
  input  logic [7:0]            iq_sc_wbuffer_id_i,
  input  logic [2:0]            iq_sc_xbar_rob_num_i,
  input  logic [1:0]            iq_sc_cacheline_state_offset0_i,
  input  logic [1:0]            iq_sc_cacheline_state_offset1_i,
  // data SRAM
  output logic                  sram_en_o,
  output logic                  sram_wen_o,
  output logic [6:0]            sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  // write buffer
  output logic                  wbuf_rd_en_o,
  output logic [7:0]            wbuf_rd_id_o,
  input  logic [DATA_WIDTH-1:0] wbuf_rdata_i,
  // linefill buffer
  output logic                  lfb_rd_en_o,
  output logic [6:0]            lfb_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] lfb_rdata_i,
  // channel response
  output logic                  sc_rsp_valid_o,
  output logic [1:0]            sc_rsp_ch_id_o,
  output logic [2:0]            sc_rsp_rob_num_o,
  output logic                  sc_rsp_is_write_o,
  output logic [DATA_WIDTH-1:0] sc_rsp_data_o,
  // BIU eviction write channel
  output logic                  sc_biu_wvalid_o,
  input  logic                  sc_biu_wready_i,
  output logic [5:0]            sc_biu_wid_o,
  output logic                  sc_biu_woffset_o,
  output logic                  sc_biu_wlast_o,
  output logic [DATA_WIDTH-1:0] sc_biu_wdata_o
);

  typedef enum logic [3:0] {
    IDLE,
    WR0,
    WR1,
    RD0,
    RD1,
    LF0,
    LF1,
    LF2,
    WB_RD,
    WB_SEND
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            ch_q, ch_d;
  logic [2:0]            rob_q, rob_d;
  logic [6:0]            addr_q, addr_d;
  logic [7:0]            wbid_q, wbid_d;
  logic [1:0]            dirty_q, dirty_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] beat_q, beat_d;
  logic                  beat_off_q, beat_off_d;
  logic                  beat_last_q, beat_last_d;
  logic                  beat_first_q, beat_first_d;

  logic                  wb_off;
  logic [1:0]            wb_rest;
  logic [1:0]            send_rest;

  // Opcode bit 2 and the clean/valid bit of each line state carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{iq_sc_opcode_i[2],
                         iq_sc_cacheline_state_offset0_i[0],
                         iq_sc_cacheline_state_offset1_i[0]};

  // Fields that only depend on latched op state.
  assign iq_sc_ready_o    = (state_q == IDLE);
  assign wbuf_rd_id_o     = wbid_q;
  assign sc_rsp_ch_id_o   = ch_q;
  assign sc_rsp_rob_num_o = rob_q;
  assign sc_biu_wid_o     = addr_q[6:1];
  assign sc_biu_woffset_o = beat_off_q;
  assign sc_biu_wlast_o   = beat_last_q;

  // Lowest remaining dirty offset, and what would remain after each beat.
  always_comb begin
    wb_off    = ~dirty_q[0];
    wb_rest   = dirty_q & ~(wb_off ? 2'b10 : 2'b01);
    send_rest = dirty_q & ~(beat_off_q ? 2'b10 : 2'b01);
  end

  // Next-state and strobe generation for the single-op sequencer.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    rob_d        = rob_q;
    addr_d       = addr_q;
    wbid_d       = wbid_q;
    dirty_d      = dirty_q;
    cap_d        = cap_q;
    beat_d       = beat_q;
    beat_off_d   = beat_off_q;
    beat_last_d  = beat_last_q;
    beat_first_d = beat_first_q;

    sram_en_o         = 1'b0;
    sram_wen_o        = 1'b0;
    sram_addr_o       = addr_q;
    sram_wdata_o      = '0;
    wbuf_rd_en_o      = 1'b0;
    lfb_rd_en_o       = 1'b0;
    lfb_rd_addr_o     = addr_q;
    sc_rsp_valid_o    = 1'b0;
    sc_rsp_is_write_o = 1'b0;
    sc_rsp_data_o     = sram_rdata_i;
    sc_biu_wvalid_o   = 1'b0;
    // SRAM data is only live in the first send cycle; stalls replay the held copy.
    sc_biu_wdata_o    = beat_first_q ? sram_rdata_i : beat_q;

    unique case (state_q)
      IDLE: begin
        if (iq_sc_valid_i) begin
          ch_d    = iq_sc_channel_id_i;
          rob_d   = iq_sc_xbar_rob_num_i;
          addr_d  = iq_sc_set_way_offset_i;
          wbid_d  = iq_sc_wbuffer_id_i;
          dirty_d = {iq_sc_cacheline_state_offset1_i[1],
                     iq_sc_cacheline_state_offset0_i[1]};
          unique case (iq_sc_opcode_i[1:0])
            2'd0:    state_d = WR0;
            2'd1:    state_d = RD0;
            2'd2:    state_d = LF0;
            default: state_d = WB_RD;
          endcase
        end
      end
      WR0: begin
        wbuf_rd_en_o = 1'b1;
        state_d      = WR1;
      end
      WR1: begin
        sram_en_o         = 1'b1;
        sram_wen_o        = 1'b1;
        sram_wdata_o      = wbuf_rdata_i;
        sc_rsp_valid_o    = 1'b1;
        sc_rsp_is_write_o = 1'b1;
        state_d           = IDLE;
      end
      RD0: begin
        sram_en_o = 1'b1;
        state_d   = RD1;
      end
      RD1: begin
        sc_rsp_valid_o = 1'b1;
        sc_rsp_data_o  = sram_rdata_i;
        state_d        = IDLE;
      end
      LF0: begin
        lfb_rd_en_o   = 1'b1;
        lfb_rd_addr_o = {addr_q[6:1], 1'b0};
        state_d       = LF1;
      end
      LF1: begin
        sram_en_o     = 1'b1;
        sram_wen_o    = 1'b1;
        sram_addr_o   = {addr_q[6:1], 1'b0};
        sram_wdata_o  = lfb_rdata_i;
        lfb_rd_en_o   = 1'b1;
        lfb_rd_addr_o = {addr_q[6:1], 1'b1};
        if (!addr_q[0]) cap_d = lfb_rdata_i;
        state_d       = LF2;
      end
      LF2: begin
        sram_en_o      = 1'b1;
        sram_wen_o     = 1'b1;
        sram_addr_o    = {addr_q[6:1], 1'b1};
        sram_wdata_o   = lfb_rdata_i;
        sc_rsp_valid_o = 1'b1;
        sc_rsp_data_o  = addr_q[0] ? lfb_rdata_i : cap_q;
        state_d        = IDLE;
      end
      WB_RD: begin
        if (dirty_q == 2'b00) begin
          state_d = IDLE;
        end else begin
          sram_en_o    = 1'b1;
          sram_addr_o  = {addr_q[6:1], wb_off};
          beat_off_d   = wb_off;
          beat_last_d  = (wb_rest == 2'b00);
          beat_first_d = 1'b1;
          state_d      = WB_SEND;
        end
      end
      WB_SEND: begin
        sc_biu_wvalid_o = 1'b1;
        if (beat_first_q) beat_d = sram_rdata_i;
        beat_first_d = 1'b0;
        if (sc_biu_wready_i) begin
          dirty_d = send_rest;
          state_d = (send_rest != 2'b00) ? WB_RD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and op-field registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      rob_q        <= '0;
      addr_q       <= '0;
      wbid_q       <= '0;
      dirty_q      <= '0;
      cap_q        <= '0;
      beat_q       <= '0;
      beat_off_q   <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      rob_q        <= rob_d;
      addr_q       <= addr_d;
      wbid_q       <= wbid_d;
      dirty_q      <= dirty_d;
      cap_q        <= cap_d;
      beat_q       <= beat_d;
      beat_off_q   <= beat_off_d;
      beat_last_q  <= beat_last_d;
      beat_first_q <= beat_first_d;
    end
  end

endmodule

// File: tb/tb_bank_sram_ctrl.sv
// Bench for bank_sram_ctrl: per-op expectation records built from the op
// semantics, with behavioural SRAM / write-buffer / linefill-buffer models.
module tb_bank_sram_ctrl;
  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          iq_sc_valid_i = 1'b0;
  logic          iq_sc_ready_o;
  logic [1:0]    iq_sc_channel_id_i = '0;
  logic [2:0]    iq_sc_opcode_i = '0;
  logic [6:0]    iq_sc_set_way_offset_i = '0;
  logic [7:0]    iq_sc_wbuffer_id_i = '0;
  logic [2:0]    iq_sc_xbar_rob_num_i = '0;
  logic [1:0]    iq_sc_cacheline_state_offset0_i = '0;
  logic [1:0]    iq_sc_cacheline_state_offset1_i = '0;
  logic          sram_en_o, sram_wen_o;
  logic [6:0]    sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [DW-1:0] sram_rdata_i = '0;
  logic          wbuf_rd_en_o;
  logic [7:0]    wbuf_rd_id_o;
  logic [DW-1:0] wbuf_rdata_i = '0;
  logic          lfb_rd_en_o;
  logic [6:0]    lfb_rd_addr_o;
  logic [DW-1:0] lfb_rdata_i = '0;
  logic          sc_rsp_valid_o;
  logic [1:0]    sc_rsp_ch_id_o;
  logic [2:0]    sc_rsp_rob_num_o;
  logic          sc_rsp_is_write_o;
  logic [DW-1:0] sc_rsp_data_o;
  logic          sc_biu_wvalid_o;
  logic          sc_biu_wready_i = 1'b0;
  logic [5:0]    sc_biu_wid_o;
  logic          sc_biu_woffset_o;
  logic          sc_biu_wlast_o;
  logic [DW-1:0] sc_biu_wdata_o;

  bank_sram_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .iq_sc_valid_i(iq_sc_valid_i), .iq_sc_ready_o(iq_sc_ready_o),
    .iq_sc_channel_id_i(iq_sc_channel_id_i), .iq_sc_opcode_i(iq_sc_opcode_i),
    .iq_sc_set_way_offset_i(iq_sc_set_way_offset_i),
    .iq_sc_wbuffer_id_i(iq_sc_wbuffer_id_i),
    .iq_sc_xbar_rob_num_i(iq_sc_xbar_rob_num_i),
    .iq_sc_cacheline_state_offset0_i(iq_sc_cacheline_state_offset0_i),
    .iq_sc_cacheline_state_offset1_i(iq_sc_cacheline_state_offset1_i),
    .sram_en_o(sram_en_o), .sram_wen_o(sram_wen_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .wbuf_rd_en_o(wbuf_rd_en_o), .wbuf_rd_id_o(wbuf_rd_id_o), .wbuf_rdata_i(wbuf_rdata_i),
    .lfb_rd_en_o(lfb_rd_en_o), .lfb_rd_addr_o(lfb_rd_addr_o), .lfb_rdata_i(lfb_rdata_i),
    .sc_rsp_valid_o(sc_rsp_valid_o), .sc_rsp_ch_id_o(sc_rsp_ch_id_o),
    .sc_rsp_rob_num_o(sc_rsp_rob_num_o), .sc_rsp_is_write_o(sc_rsp_is_write_o),
    .sc_rsp_data_o(sc_rsp_data_o),
    .sc_biu_wvalid_o(sc_biu_wvalid_o), .sc_biu_wready_i(sc_biu_wready_i),
    .sc_biu_wid_o(sc_biu_wid_o), .sc_biu_woffset_o(sc_biu_woffset_o),
    .sc_biu_wlast_o(sc_biu_wlast_o), .sc_biu_wdata_o(sc_biu_wdata_o)
  );

  // One record per clock cycle: inputs to drive and outputs required.
  typedef struct {
    bit rst; bit chk; bit valid; bit wready;
    logic [1:0] ch; logic [2:0] opc; logic [6:0] addr; logic [7:0] wbid;
    logic [2:0] rob; logic [1:0] s0; logic [1:0] s1;
    bit e_ready; bit e_sen; bit e_wen; logic [6:0] e_saddr; logic [DW-1:0] e_swdata;
    bit e_wben; logic [7:0] e_wbid; bit e_lfen; logic [6:0] e_lfaddr;
    bit e_rsp; logic [1:0] e_ch; logic [2:0] e_rob; bit e_isw; logic [DW-1:0] e_rdata;
    bit e_wv; logic [5:0] e_wid; bit e_woff; bit e_wlast; logic [DW-1:0] e_wdata;
  } rec_t;

  rec_t q[$];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] env_mem [128];
  logic [DW-1:0] wbuf_mem[256];
  logic [DW-1:0] lfb_mem [128];
  logic [DW-1:0] nxt_s, nxt_w, nxt_l;

  int checks = 0;
  int errors = 0;
  int beats, rsps;
  logic [DW-1:0] last_rsp_data;
  logic last_rsp_isw, last_woff;

  function automatic logic [DW-1:0] junk();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic rec_t blank(input bit ready);
    rec_t r;
    r = '{default: '0};
    r.chk = 1'b1;
    r.e_ready = ready;
    return r;
  endfunction

  function automatic rec_t acc(input logic [1:0] ch, input logic [2:0] opc, input logic [6:0] addr,
                               input logic [7:0] wbid, input logic [2:0] rob,
                               input logic [1:0] s0, input logic [1:0] s1);
    rec_t r;
    r = blank(1'b1);
    r.valid = 1'b1; r.ch = ch; r.opc = opc; r.addr = addr; r.wbid = wbid;
    r.rob = rob; r.s0 = s0; r.s1 = s1;
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) q.push_back(blank(1'b1));
  endtask

  task automatic do_read(input logic [1:0] ch, input logic [6:0] addr, input logic [2:0] rob,
                         input logic [2:0] opc);
    rec_t r;
    q.push_back(acc(ch, opc, addr, 8'h00, rob, 2'b00, 2'b00));
    r = blank(1'b0); r.e_sen = 1; r.e_saddr = addr; q.push_back(r);
    r = blank(1'b0); r.e_rsp = 1; r.e_ch = ch; r.e_rob = rob; r.e_rdata = ref_mem[addr];
    q.push_back(r);
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [6:0] addr, input logic [7:0] wbid,
                          input logic [2:0] rob);
    rec_t r;
    q.push_back(acc(ch, 3'b000, addr, wbid, rob, 2'b00, 2'b00));
    r = blank(1'b0); r.e_wben = 1; r.e_wbid = wbid; q.push_back(r);
    r = blank(1'b0); r.e_sen = 1; r.e_wen = 1; r.e_saddr = addr; r.e_swdata = wbuf_mem[wbid];
    r.e_rsp = 1; r.e_ch = ch; r.e_rob = rob; r.e_isw = 1; q.push_back(r);
    ref_mem[addr] = wbuf_mem[wbid];
  endtask

  task automatic do_lf(input logic [1:0] ch, input logic [6:0] addr, input logic [2:0] rob);
    rec_t r;
    logic [6:0] a0, a1;
    a0 = {addr[6:1], 1'b0};
    a1 = {addr[6:1], 1'b1};
    q.push_back(acc(ch, 3'b010, addr, 8'h00, rob, 2'b00, 2'b00));
    r = blank(1'b0); r.e_lfen = 1; r.e_lfaddr = a0; q.push_back(r);
    r = blank(1'b0); r.e_sen = 1; r.e_wen = 1; r.e_saddr = a0; r.e_swdata = lfb_mem[a0];
    r.e_lfen = 1; r.e_lfaddr = a1; q.push_back(r);
    r = blank(1'b0); r.e_sen = 1; r.e_wen = 1; r.e_saddr = a1; r.e_swdata = lfb_mem[a1];
    r.e_rsp = 1; r.e_ch = ch; r.e_rob = rob; r.e_rdata = lfb_mem[addr]; q.push_back(r);
    ref_mem[a0] = lfb_mem[a0];
    ref_mem[a1] = lfb_mem[a1];
  endtask

  // Writeback: dirty offsets evicted lowest first; stallN = wready-low cycles on beat N.
  task automatic do_wb(input logic [5:0] line, input logic [1:0] s0, input logic [1:0] s1,
                       input int stall0, input int stall1);
    rec_t r;
    logic [1:0] mask;
    int st;
    mask = {s1[1], s0[1]};
    q.push_back(acc(2'd0, 3'b011, {line, 1'b0}, 8'h00, 3'd0, s0, s1));
    if (mask == 2'b00) q.push_back(blank(1'b0));
    for (int off = 0; off < 2; off++) begin
      if (mask[off]) begin
        r = blank(1'b0); r.e_sen = 1; r.e_saddr = {line, off[0]}; q.push_back(r);
        st = (off == 0) ? stall0 : stall1;
        for (int k = 0; k <= st; k++) begin
          r = blank(1'b0);
          r.e_wv = 1; r.e_wid = line; r.e_woff = off[0];
          r.e_wlast = (off == 1) || !mask[1];
          r.e_wdata = ref_mem[{line, off[0]}];
          r.wready = (k == st);
          q.push_back(r);
        end
      end
    end
  endtask

  // Single drive/compare process: one record per cycle, inputs at negedge.
  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      sram_rdata_i = nxt_s;
      wbuf_rdata_i = nxt_w;
      lfb_rdata_i  = nxt_l;
      rst_i = r.rst;
      iq_sc_valid_i = r.valid;
      iq_sc_channel_id_i = r.ch;
      iq_sc_opcode_i = r.opc;
      iq_sc_set_way_offset_i = r.addr;
      iq_sc_wbuffer_id_i = r.wbid;
      iq_sc_xbar_rob_num_i = r.rob;
      iq_sc_cacheline_state_offset0_i = r.s0;
      iq_sc_cacheline_state_offset1_i = r.s1;
      sc_biu_wready_i = r.wready;
      #1;
      if (r.chk) begin
        chk("ready", iq_sc_ready_o, r.e_ready);
        chk("sram_en", sram_en_o, r.e_sen);
        if (r.e_sen) begin
          chk("sram_wen", sram_wen_o, r.e_wen);
          chk("sram_addr", sram_addr_o, r.e_saddr);
          if (r.e_wen) chk("sram_wdata", sram_wdata_o, r.e_swdata);
        end
        chk("wbuf_en", wbuf_rd_en_o, r.e_wben);
        if (r.e_wben) chk("wbuf_id", wbuf_rd_id_o, r.e_wbid);
        chk("lfb_en", lfb_rd_en_o, r.e_lfen);
        if (r.e_lfen) chk("lfb_addr", lfb_rd_addr_o, r.e_lfaddr);
        chk("rsp_valid", sc_rsp_valid_o, r.e_rsp);
        if (r.e_rsp) begin
          chk("rsp_ch", sc_rsp_ch_id_o, r.e_ch);
          chk("rsp_rob", sc_rsp_rob_num_o, r.e_rob);
          chk("rsp_isw", sc_rsp_is_write_o, r.e_isw);
          if (!r.e_isw) chk("rsp_data", sc_rsp_data_o, r.e_rdata);
        end
        chk("wvalid", sc_biu_wvalid_o, r.e_wv);
        if (r.e_wv) begin
          chk("wid", sc_biu_wid_o, r.e_wid);
          chk("woffset", sc_biu_woffset_o, r.e_woff);
          chk("wlast", sc_biu_wlast_o, r.e_wlast);
          chk("wdata", sc_biu_wdata_o, r.e_wdata);
        end
      end
      if (sc_rsp_valid_o === 1'b1) begin
        rsps++;
        last_rsp_data = sc_rsp_data_o;
        last_rsp_isw = sc_rsp_is_write_o;
      end
      if (sc_biu_wvalid_o === 1'b1 && sc_biu_wready_i) begin
        beats++;
        last_woff = sc_biu_woffset_o;
      end
      // Environment memories: respond one cycle after a read strobe, junk otherwise.
      if (sram_en_o === 1'b1 && sram_wen_o === 1'b1) env_mem[sram_addr_o] = sram_wdata_o;
      nxt_s = (sram_en_o === 1'b1 && sram_wen_o === 1'b0) ? env_mem[sram_addr_o] : junk();
      nxt_w = (wbuf_rd_en_o === 1'b1) ? wbuf_mem[wbuf_rd_id_o] : junk();
      nxt_l = (lfb_rd_en_o === 1'b1) ? lfb_mem[lfb_rd_addr_o] : junk();
    end
  endtask

  task automatic clr_obs();
    beats = 0; rsps = 0; last_rsp_data = '0; last_rsp_isw = 1'b0; last_woff = 1'b0;
  endtask

  initial begin
    rec_t r;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = {8{8'(i), 24'hC0FFEE}};
      env_mem[i] = ref_mem[i];
      lfb_mem[i] = {8{8'(i), 24'h1F1F00}};
    end
    for (int i = 0; i < 256; i++) wbuf_mem[i] = {8{8'(i), 24'h57AB1E}};
    ref_mem[7'h25] = {32{8'hAA}};
    env_mem[7'h25] = {32{8'hAA}};
    wbuf_mem[8'h17] = {32{8'h5C}};
    lfb_mem[7'h30] = {32{8'h30}};
    lfb_mem[7'h31] = {32{8'h31}};
    nxt_s = '0; nxt_w = '0; nxt_l = '0;
    clr_obs();

    // power-on reset, then reset-state checks
    r = blank(1'b0); r.rst = 1; r.chk = 0;
    q.push_back(r); q.push_back(r);
    idle(2);
    run_q();

    // read
    clr_obs();
    do_read(2'd1, 7'h25, 3'd5, 3'b001);
    idle(1);
    run_q();
    chk("rd_lit_data", last_rsp_data, {32{8'hAA}});
    chk("rd_lit_count", rsps, 1);

    // write
    clr_obs();
    do_write(2'd2, 7'h10, 8'h17, 3'd3);
    idle(1);
    run_q();
    chk("wr_lit_mem", env_mem[7'h10], {32{8'h5C}});
    chk("wr_lit_isw", last_rsp_isw, 1'b1);

    // linefill for offset 1, then offset 0 followed back-to-back by a read with opcode bit 2 set
    clr_obs();
    do_lf(2'd0, 7'h31, 3'd6);
    idle(1);
    run_q();
    chk("lf_lit_data", last_rsp_data, {32{8'h31}});
    chk("lf_lit_mem0", env_mem[7'h30], {32{8'h30}});
    do_lf(2'd3, 7'h40, 3'd1);
    do_read(2'd0, 7'h40, 3'd2, 3'b101);
    idle(1);
    run_q();

    // writeback both dirty, beat0 stalled 3 cycles
    clr_obs();
    do_wb(6'h08, 2'b10, 2'b10, 3, 0);
    idle(1);
    run_q();
    chk("wb2_lit_beats", beats, 2);
    chk("wb2_lit_lastoff", last_woff, 1'b1);
    chk("wb2_lit_norsp", rsps, 0);

    // writeback partial (offset1 only), and encoding 11/01 (offset0 only)
    clr_obs();
    do_wb(6'h12, 2'b00, 2'b10, 0, 1);
    idle(1);
    run_q();
    chk("wbp_lit_beats", beats, 1);
    chk("wbp_lit_off", last_woff, 1'b1);
    clr_obs();
    do_wb(6'h2A, 2'b11, 2'b01, 2, 0);
    run_q();
    chk("wb11_lit_beats", beats, 1);

    // clean writeback
    clr_obs();
    do_wb(6'h05, 2'b01, 2'b00, 0, 0);
    idle(1);
    run_q();
    chk("wbc_lit_beats", beats, 0);

    // reset while a beat is held in WB_SEND, then a normal read
    clr_obs();
    q.push_back(acc(2'd0, 3'b011, {6'h09, 1'b0}, 8'h00, 3'd0, 2'b10, 2'b10));
    r = blank(1'b0); r.e_sen = 1; r.e_saddr = {6'h09, 1'b0}; q.push_back(r);
    r = blank(1'b0); r.e_wv = 1; r.e_wid = 6'h09; r.e_woff = 0; r.e_wlast = 0;
    r.e_wdata = ref_mem[{6'h09, 1'b0}];
    q.push_back(r);
    r.rst = 1; q.push_back(r);
    idle(1);
    do_read(2'd1, 7'h26, 3'd7, 3'b001);
    idle(1);
    run_q();
    chk("rst_lit_beats", beats, 0);
    chk("rst_lit_rsps", rsps, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
